// File: rtl/game_pkg.sv
// game_pkg: state encoding and default timing constants for the Flappy VGA
// game controller, shared with the display and seven-segment logic.
package game_pkg;

    // Game state encoding; RSVD is never entered in normal operation
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10,
        RSVD = 2'b11
    } game_state_t;

    // Default timing for a 50 MHz board clock
    localparam int PIPE_TICK_DIV_DEFAULT    = 524288;
    localparam int PHYS_TICK_DIV_DEFAULT    = 1048576;
    localparam int DEBOUNCE_CYCLES_DEFAULT  = 500000;
    localparam int OVER_HOLD_CYCLES_DEFAULT = 50000000;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/game_sequencer_debounce.sv
// btn_debounce: two-flop synchronizer followed by a stability counter.
// The accepted level follows the synchronized button only after it has
// differed from the accepted level for DEBOUNCE_CYCLES consecutive samples;
// press is a one-cycle pulse on each 0->1 change of the accepted level.
module btn_debounce
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
)(
    input  logic board_clk,
    input  logic Reset,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the board_clk domain
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
        end
    end

    // Count consecutive samples that disagree with the accepted level
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync_b;
                press <= sync_b;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: central Flappy VGA controller. Debounces start/jump,
// runs the IDLE/PLAY/OVER state machine, produces the start/ack pulses,
// the stop level, the pipe/physics tick enables and the session high score.
// Optional feature macro: GAME_SEQ_HIGH_SCORE_EN (high-score register).
module game_sequencer
    import game_pkg::*;
#(
    parameter int PIPE_TICK_DIV    = PIPE_TICK_DIV_DEFAULT,
    parameter int PHYS_TICK_DIV    = PHYS_TICK_DIV_DEFAULT,
    parameter int DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEFAULT,
    parameter int OVER_HOLD_CYCLES = OVER_HOLD_CYCLES_DEFAULT
)(
    input  logic       board_clk,
    input  logic       Reset,
    input  logic       btn_start,
    input  logic       btn_jump,
    input  logic       lose_in,
    input  logic [3:0] score_in,
    output logic       start_pulse,
    output logic       ack_pulse,
    output logic       stop,
    output logic       pipe_tick,
    output logic       phys_tick,
    output logic       jump_pulse,
    output logic [1:0] state,
    output logic [3:0] high_score
);

    localparam int PIPE_W = cnt_width(PIPE_TICK_DIV);
    localparam int PHYS_W = cnt_width(PHYS_TICK_DIV);
    localparam int HOLD_W = cnt_width(OVER_HOLD_CYCLES);
    localparam logic [PIPE_W-1:0] PIPE_LAST = PIPE_W'(PIPE_TICK_DIV - 1);
    localparam logic [PHYS_W-1:0] PHYS_LAST = PHYS_W'(PHYS_TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(OVER_HOLD_CYCLES - 1);

    game_state_t       state_q;
    game_state_t       state_d;
    logic [PIPE_W-1:0] pipe_cnt;
    logic [PIPE_W-1:0] pipe_cnt_d;
    logic [PHYS_W-1:0] phys_cnt;
    logic [PHYS_W-1:0] phys_cnt_d;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_d;

    logic start_press;
    logic jump_press;
    logic start_ok;
    logic score_capture;
    logic start_pulse_d;
    logic ack_pulse_d;
    logic stop_d;
    logic pipe_tick_d;
    logic phys_tick_d;
    logic jump_pulse_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_start_db (
        .board_clk (board_clk),
        .Reset     (Reset),
        .btn       (btn_start),
        .press     (start_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_jump_db (
        .board_clk (board_clk),
        .Reset     (Reset),
        .btn       (btn_jump),
        .press     (jump_press)
    );

    // A start press that lands on a start/ack pulse cycle is swallowed
    assign start_ok = start_press && !start_pulse && !ack_pulse;

    // Next state, counter updates and next values of the registered outputs
    always_comb begin
        state_d       = state_q;
        pipe_cnt_d    = pipe_cnt;
        phys_cnt_d    = phys_cnt;
        hold_cnt_d    = hold_cnt;
        start_pulse_d = 1'b0;
        ack_pulse_d   = 1'b0;
        stop_d        = 1'b0;
        pipe_tick_d   = 1'b0;
        phys_tick_d   = 1'b0;
        jump_pulse_d  = 1'b0;
        score_capture = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d       = PLAY;
                    start_pulse_d = 1'b1;
                    pipe_cnt_d    = '0;
                    phys_cnt_d    = '0;
                end
            end

            PLAY: begin
                pipe_cnt_d = (pipe_cnt == PIPE_LAST) ? '0 : pipe_cnt + PIPE_W'(1);
                phys_cnt_d = (phys_cnt == PHYS_LAST) ? '0 : phys_cnt + PHYS_W'(1);
                if (lose_in) begin
                    // Losing overrides any tick or jump due this cycle
                    state_d       = OVER;
                    stop_d        = 1'b1;
                    hold_cnt_d    = HOLD_LAST;
                    score_capture = 1'b1;
                end else begin
                    pipe_tick_d  = (pipe_cnt == PIPE_LAST);
                    phys_tick_d  = (phys_cnt == PHYS_LAST);
                    jump_pulse_d = jump_press;
                end
            end

            OVER: begin
                stop_d = 1'b1;
                if (hold_cnt != '0) begin
                    // Presses during the hold window are dropped, not queued
                    hold_cnt_d = hold_cnt - HOLD_W'(1);
                end else if (start_ok) begin
                    state_d     = IDLE;
                    stop_d      = 1'b0;
                    ack_pulse_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            pipe_cnt    <= '0;
            phys_cnt    <= '0;
            hold_cnt    <= '0;
            start_pulse <= 1'b0;
            ack_pulse   <= 1'b0;
            stop        <= 1'b0;
            pipe_tick   <= 1'b0;
            phys_tick   <= 1'b0;
            jump_pulse  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pipe_cnt    <= pipe_cnt_d;
            phys_cnt    <= phys_cnt_d;
            hold_cnt    <= hold_cnt_d;
            start_pulse <= start_pulse_d;
            ack_pulse   <= ack_pulse_d;
            stop        <= stop_d;
            pipe_tick   <= pipe_tick_d;
            phys_tick   <= phys_tick_d;
            jump_pulse  <= jump_pulse_d;
        end
    end

    assign state = state_q;

`ifdef GAME_SEQ_HIGH_SCORE_EN
    logic [3:0] high_score_q;

    // Keep the best score seen at the end of each game since Reset
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            high_score_q <= 4'd0;
        end else if (score_capture && (score_in > high_score_q)) begin
            high_score_q <= score_in;
        end
    end

    assign high_score = high_score_q;
`else
    logic unused_score;

    assign unused_score = ^{score_in, score_capture};
    assign high_score   = 4'd0;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: randomized self-checking bench for game_sequencer.
// The reference model is a timeline of game events (start, lose, ack,
// jump cycles) from which every output is derived arithmetically.
module tb_game_sequencer;

    localparam int PIPE_DIV = 8;
    localparam int PHYS_DIV = 16;
    localparam int DEB      = 4;
    localparam int HOLD     = 10;
    // Drive cycle of a clean press -> cycle its one-cycle pulse is visible
    localparam int LAT      = DEB + 3;
`ifdef GAME_SEQ_HIGH_SCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    logic       board_clk = 1'b0;
    logic       Reset;
    logic       btn_start;
    logic       btn_jump;
    logic       lose_in;
    logic [3:0] score_in;
    logic       start_pulse;
    logic       ack_pulse;
    logic       stop;
    logic       pipe_tick;
    logic       phys_tick;
    logic       jump_pulse;
    logic [1:0] state;
    logic [3:0] high_score;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference timeline
    int         m_start = -1;
    int         m_over  = -1;
    int         m_ack   = -1;
    int         m_jumps[$];
    logic [3:0] m_hs_prev = 4'd0;
    logic [3:0] m_hs_new  = 4'd0;

    game_sequencer #(
        .PIPE_TICK_DIV    (PIPE_DIV),
        .PHYS_TICK_DIV    (PHYS_DIV),
        .DEBOUNCE_CYCLES  (DEB),
        .OVER_HOLD_CYCLES (HOLD)
    ) dut (
        .board_clk   (board_clk),
        .Reset       (Reset),
        .btn_start   (btn_start),
        .btn_jump    (btn_jump),
        .lose_in     (lose_in),
        .score_in    (score_in),
        .start_pulse (start_pulse),
        .ack_pulse   (ack_pulse),
        .stop        (stop),
        .pipe_tick   (pipe_tick),
        .phys_tick   (phys_tick),
        .jump_pulse  (jump_pulse),
        .state       (state),
        .high_score  (high_score)
    );

    always #5 board_clk = ~board_clk;

    task automatic tick();
        @(negedge board_clk);
        cyc++;
    endtask

    function automatic logic [11:0] obs();
        return {start_pulse, ack_pulse, stop, pipe_tick, phys_tick, jump_pulse, state, high_score};
    endfunction

    // Expected outputs in cycle c, from the game event timeline
    function automatic logic [11:0] exp_out(input int c);
        logic       play;
        logic       over;
        logic       pt;
        logic       ph;
        logic       jp;
        logic [1:0] st;
        logic [3:0] hs;
        play = (m_start >= 0) && (c >= m_start) && ((m_over < 0) || (c < m_over));
        over = (m_over >= 0) && (c >= m_over) && ((m_ack < 0) || (c < m_ack));
        st   = play ? 2'b01 : (over ? 2'b10 : 2'b00);
        pt   = play && (c > m_start) && (((c - m_start) % PIPE_DIV) == 0);
        ph   = play && (c > m_start) && (((c - m_start) % PHYS_DIV) == 0);
        jp   = 1'b0;
        foreach (m_jumps[i]) if (m_jumps[i] == c) jp = 1'b1;
        hs   = ((m_over >= 0) && (c >= m_over)) ? m_hs_new : m_hs_prev;
        return {(c == m_start), (c == m_ack), over, pt, ph, jp, st, hs};
    endfunction

    function automatic void new_game(input int s);
        m_start   = s;
        m_over    = -1;
        m_ack     = -1;
        m_jumps.delete();
        m_hs_prev = m_hs_new;
    endfunction

    function automatic void lose_at(input int c, input logic [3:0] score);
        m_over   = c;
        m_hs_new = !HS_EN ? 4'd0 : ((score > m_hs_prev) ? score : m_hs_prev);
    endfunction

    function automatic void model_reset();
        m_start   = -1;
        m_over    = -1;
        m_ack     = -1;
        m_jumps.delete();
        m_hs_prev = 4'd0;
        m_hs_new  = 4'd0;
    endfunction

    task automatic test_reset();
        Reset     = 1'b1;
        btn_start = 1'b0;
        btn_jump  = 1'b0;
        lose_in   = 1'b0;
        score_in  = 4'd0;
        repeat (3) tick();
        n_cmp++;
        if (obs() !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_state cyc=%0d got=%h expected=%h", cyc, obs(), 12'h000);
        end
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic test_bounce();
        int half;
        half = $urandom_range(1, 2);
        for (int i = 0; i < 30; i++) begin
            btn_start = (i < 20) ? (((i / half) % 2) == 0) : 1'b0;
            tick();
            n_cmp++;
            if (obs() !== exp_out(cyc)) begin
                n_fail++;
                $display("FAIL bounce cyc=%0d got=%h expected=%h", cyc, obs(), exp_out(cyc));
            end
        end
    endtask

    task automatic test_jump_idle();
        int h;
        h = $urandom_range(4, 8);
        btn_jump = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            tick();
            n_cmp++;
            if (obs() !== exp_out(cyc)) begin
                n_fail++;
                $display("FAIL jump_idle cyc=%0d got=%h expected=%h", cyc, obs(), exp_out(cyc));
            end
            if (i == h) btn_jump = 1'b0;
        end
    endtask

    task automatic test_start();
        int h;
        h = $urandom_range(5, 12);
        new_game(cyc + LAT);
        btn_start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            n_cmp++;
            if (obs() !== exp_out(cyc)) begin
                n_fail++;
                $display("FAIL start_ticks cyc=%0d got=%h expected=%h", cyc, obs(), exp_out(cyc));
            end
            if (i == h) btn_start = 1'b0;
        end
    endtask

    task automatic test_jump_play();
        for (int r = 0; r < 2; r++) begin
            int g;
            int h;
            g = $urandom_range(0, 5);
            h = $urandom_range(4, 7);
            for (int i = 0; i < g + 20; i++) begin
                if (i == g) begin
                    m_jumps.push_back(cyc + LAT);
                    btn_jump = 1'b1;
                end
                if (i == g + h) btn_jump = 1'b0;
                tick();
                n_cmp++;
                if (obs() !== exp_out(cyc)) begin
                    n_fail++;
                    $display("FAIL jump_play cyc=%0d got=%h expected=%h", cyc, obs(), exp_out(cyc));
                end
            end
        end
    endtask

    task automatic test_lose_hold();
        int r;
        int g;
        int h;
        r = $urandom_range(0, 2);
        lose_in  = 1'b1;
        score_in = 4'd5;
        lose_at(cyc + 1, 4'd5);
        for (int i = 1; i <= 25; i++) begin
            tick();
            n_cmp++;
            if (obs() !== exp_out(cyc)) begin
                n_fail++;
                $display("FAIL lose_hold cyc=%0d got=%h expected=%h", cyc, obs(), exp_out(cyc));
            end
            if (i == 1) begin
                lose_in  = 1'b0;
                btn_jump = 1'b1;
            end
            if (i == 5) btn_jump = 1'b0;
            if (i == 1 + r) btn_start = 1'b1;
            if (i == 5 + r) btn_start = 1'b0;
        end
        g = $urandom_range(0, 6);
        h = $urandom_range(4, 8);
        for (int i = 0; i < g + 20; i++) begin
            if (i == g) begin
                m_ack     = cyc + LAT;
                btn_start = 1'b1;
            end
            if (i == g + h) btn_start = 1'b0;
            tick();
            n_cmp++;
            if (obs() !== exp_out(cyc)) begin
                n_fail++;
                $display("FAIL ack_after_hold cyc=%0d got=%h expected=%h", cyc, obs(), exp_out(cyc));
            end
        end
    endtask

    task automatic test_high_score_keep();
        int j0;
        j0 = 8 + $urandom_range(3, 10);
        new_game(cyc + LAT);
        btn_start = 1'b1;
        for (int i = 1; i <= j0 + 30; i++) begin
            tick();
            n_cmp++;
            if (obs() !== exp_out(cyc)) begin
                n_fail++;
                $display("FAIL hs_keep_collision cyc=%0d got=%h expected=%h", cyc, obs(), exp_out(cyc));
            end
            if (i == 6) btn_start = 1'b0;
            if (i == j0) btn_jump = 1'b1;
            if (i == j0 + 5) btn_jump = 1'b0;
            if (i == j0 + 6) begin
                lose_in  = 1'b1;
                score_in = 4'd3;
                lose_at(cyc + 1, 4'd3);
            end
            if (i == j0 + 7) lose_in = 1'b0;
            if (i == j0 + 20) begin
                m_ack     = cyc + LAT;
                btn_start = 1'b1;
            end
            if (i == j0 + 26) btn_start = 1'b0;
        end
    endtask

    task automatic test_reset_mid_play();
        int run;
        run = LAT + $urandom_range(3, 20);
        new_game(cyc + LAT);
        btn_start = 1'b1;
        for (int i = 1; i <= run; i++) begin
            tick();
            n_cmp++;
            if (obs() !== exp_out(cyc)) begin
                n_fail++;
                $display("FAIL pre_reset_play cyc=%0d got=%h expected=%h", cyc, obs(), exp_out(cyc));
            end
            if (i == 6) btn_start = 1'b0;
        end
        #3;
        Reset = 1'b1;
        #1;
        n_cmp++;
        if (obs() !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_async cyc=%0d got=%h expected=%h", cyc, obs(), 12'h000);
        end
        model_reset();
        repeat (2) tick();
        Reset = 1'b0;
        new_game(cyc + LAT);
        btn_start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            n_cmp++;
            if (obs() !== exp_out(cyc)) begin
                n_fail++;
                $display("FAIL after_reset_game cyc=%0d got=%h expected=%h", cyc, obs(), exp_out(cyc));
            end
            if (i == 6) btn_start = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_jump_idle();
        test_start();
        test_jump_play();
        test_lose_hold();
        test_jump_idle();
        test_high_score_keep();
        test_reset_mid_play();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Central game controller for the Flappy VGA design, clocked on board_clk. It debounces the start and jump buttons and runs the IDLE/PLAY/OVER game state machine. It issues one-cycle start/ack pulses and a stop level to the pipe, obstacle and flight blocks, and generates the pipe-scroll and physics tick enables that replace raw clock-divider taps. It also records the session high score.

## Interface
- PIPE_TICK_DIV, 524288: board_clk cycles per pipe_tick.
- PHYS_TICK_DIV, 1048576: board_clk cycles per phys_tick.
- DEBOUNCE_CYCLES, 500000: cycles a synchronized button must stay stable before its level is accepted.
- OVER_HOLD_CYCLES, 50000000: cycles after entering OVER during which start presses are ignored.
- board_clk  in  1  system clock, 50 MHz.
- Reset  in  1  asynchronous, active-high; clock board_clk.
- btn_start  in  1  raw start/ack button, asynchronous.
- btn_jump  in  1  raw jump button, asynchronous.
- lose_in  in  1  lose level from obstacle logic.
- score_in  in  4  current score from pipe block.
- start_pulse  out  1  one-cycle pulse starting a game.
- ack_pulse  out  1  one-cycle pulse acknowledging game over.
- stop  out  1  high while in OVER.
- pipe_tick  out  1  one-cycle pipe-advance enable.
- phys_tick  out  1  one-cycle physics-update enable.
- jump_pulse  out  1  one-cycle debounced jump press.
- state  out  2  00 IDLE, 01 PLAY, 10 OVER, 11 unused.
- high_score  out  4  best score since Reset.

## Operation
- Buttons: 2-flop synchronizer, then a debounce counter. The accepted level updates only after DEBOUNCE_CYCLES consecutive equal samples. A press event is a 0->1 transition of the accepted level.
- IDLE: start press -> PLAY. start_pulse is high in the first PLAY cycle. Both tick counters clear to 0 on this transition.
- PLAY: the tick counters run 0..DIV-1 and wrap. A tick is asserted in the cycle the counter equals DIV-1. jump_pulse forwards jump press events. lose_in=1 -> OVER, and the hold counter loads OVER_HOLD_CYCLES-1.
- OVER: stop=1; ticks and jump_pulse forced to 0. The hold counter decrements to 0 and saturates. A start press with hold counter = 0 -> IDLE, with ack_pulse high in the first IDLE cycle. Start presses while the hold counter is nonzero are discarded, not queued.
- High score: on the PLAY->OVER transition, high_score <= score_in if score_in > high_score (unsigned 4-bit).
- Jump press events outside PLAY are discarded.
- State 11 is unreachable. If entered, the FSM goes to IDLE on the next cycle.

## Timing
- All outputs are registered. Reset value of every output is 0, and state=IDLE.
- Debounce latency: press event 2 + DEBOUNCE_CYCLES cycles after a clean raw edge.
- start_pulse and ack_pulse assert the cycle after the press event.
- First pipe_tick: PIPE_TICK_DIV cycles after start_pulse. Period: PIPE_TICK_DIV. phys_tick behaves the same with PHYS_TICK_DIV.
- If lose_in=1 in a PLAY cycle, the tick outputs are 0 that same cycle.
- Simultaneous lose_in and jump press in PLAY: OVER wins and jump_pulse stays 0.
- stop rises the cycle after lose_in is sampled high and falls together with the ack_pulse assertion.
- A start press during an active start_pulse or ack_pulse cycle is ignored.
- Reset mid-game: immediate return to IDLE. All counters and high_score clear. Debouncers clear to a released state.
- Counter widths are $clog2 of the respective parameter, minimum 1.

## Configuration
- GAME_SEQ_HIGH_SCORE_EN defined: high_score register and compare logic are present as described.
- GAME_SEQ_HIGH_SCORE_EN undefined: high_score is tied to 4'd0 and no register is inferred. All other behaviour is unchanged.

## Structure
- Package game_pkg: state encoding constants (IDLE=2'b00, PLAY=2'b01, OVER=2'b10) and the default divider values, shared with the display and SSD logic.
- Sub-module btn_debounce (synchronizer + stability counter + press-event output), instantiated twice with DEBOUNCE_CYCLES passed through.
- The FSM, tick counters, hold counter and high-score register live in game_sequencer.

## Test plan
Bench parameters: PIPE_TICK_DIV=8, PHYS_TICK_DIV=16, DEBOUNCE_CYCLES=4, OVER_HOLD_CYCLES=10.
- Start game: btn_start held high for 10 cycles from IDLE -> one start_pulse, state=01, first pipe_tick 8 cycles later, then every 8; phys_tick every 16.
- Bounce filtering: btn_start toggling every 2 cycles for 20 cycles -> no start_pulse, state stays 00.
- Lose and hold: lose_in=1 in PLAY with score_in=5 -> stop=1, state=10, high_score=5. A press released before the hold counter expires -> no ack_pulse. A clean press afterwards -> ack_pulse, state=00.
- High score keep: second game lost with score_in=3 -> high_score remains 5. With GAME_SEQ_HIGH_SCORE_EN undefined, high_score=0 throughout.
- Jump gating: jump press in IDLE and OVER -> no jump_pulse. Jump press in PLAY -> exactly one jump_pulse. Jump press event in the same cycle lose_in=1 -> no jump_pulse.
- Reset mid-PLAY: Reset asserted asynchronously -> all outputs 0 and state=00 immediately; high_score=0; the next game's first tick again arrives 8 cycles after start_pulse.
